// File: rtl/mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// mem_responder_pkg
//   Shared definitions for the load/store responder: access width codes (same
//   encoding the core emits in instr[13:12]), FSM state encodings and the
//   alignment-check helper used by the lane aligner.
// ---------------------------------------------------------------------------
package mem_responder_pkg;

   // Access width codes
   localparam logic [1:0] WIDTH_BYTE = 2'b00;
   localparam logic [1:0] WIDTH_HALF = 2'b01;
   localparam logic [1:0] WIDTH_WORD = 2'b10;

   // Responder FSM encodings
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_WAIT = 2'b01;
   localparam logic [1:0] ST_RESP = 2'b10;

   // An access is in error when its width code is illegal or its address is
   // not naturally aligned for that width.
   function automatic logic access_err(input logic [1:0] width,
                                       input logic [1:0] addr_lo);
      logic e;
      case (width)
         WIDTH_BYTE: e = 1'b0;
         WIDTH_HALF: e = addr_lo[0];
         WIDTH_WORD: e = |addr_lo;
         default:    e = 1'b1;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/mem_responder_lane_align.sv
// ---------------------------------------------------------------------------
// mem_responder_lane_align (combinational)
//   Little-endian lane handling for one access against one stored word.
//   Ports:
//     addr_lo   in  2   byte offset within the word
//     width     in  2   access width code
//     usignext  in  1   1 = zero-extend loads, 0 = sign-extend
//     wdata     in  32  right-aligned store data
//     rd_word   in  32  current contents of the addressed word
//     err       out 1   misaligned or illegal-width access
//     wr_word   out 32  rd_word with the addressed lanes replaced (no lanes on error)
//     ld_data   out 32  extracted and extended load value (0 on error)
// ---------------------------------------------------------------------------
module mem_responder_lane_align
   import mem_responder_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  width,
   input  logic        usignext,
   input  logic [31:0] wdata,
   input  logic [31:0] rd_word,
   output logic        err,
   output logic [31:0] wr_word,
   output logic [31:0] ld_data
);

   logic [3:0]  be_raw_s;
   logic [3:0]  be_s;
   logic [31:0] wrep_s;
   logic [31:0] ld_raw_s;
   logic [7:0]  byte_s;
   logic [15:0] half_s;
   logic        fill_s;

   // Lane selection, byte enables and load extension per access width
   always_comb begin
      err      = access_err(width, addr_lo);
      byte_s   = rd_word[{addr_lo, 3'b000} +: 8];
      half_s   = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
      fill_s   = 1'b0;
      be_raw_s = 4'b0000;
      wrep_s   = 32'h0000_0000;
      ld_raw_s = 32'h0000_0000;
      case (width)
         WIDTH_BYTE: begin
            fill_s   = ~usignext & byte_s[7];
            be_raw_s = 4'b0001 << addr_lo;
            wrep_s   = {4{wdata[7:0]}};
            ld_raw_s = {{24{fill_s}}, byte_s};
         end
         WIDTH_HALF: begin
            fill_s   = ~usignext & half_s[15];
            be_raw_s = addr_lo[1] ? 4'b1100 : 4'b0011;
            wrep_s   = {2{wdata[15:0]}};
            ld_raw_s = {{16{fill_s}}, half_s};
         end
         WIDTH_WORD: begin
            be_raw_s = 4'b1111;
            wrep_s   = wdata;
            ld_raw_s = rd_word;
         end
         default: begin
            be_raw_s = 4'b0000;
         end
      endcase
      // Erroneous accesses touch no lane and return zero
      be_s    = err ? 4'b0000 : be_raw_s;
      ld_data = err ? 32'h0000_0000 : ld_raw_s;
   end

   // Merge replicated store data into the enabled byte lanes only
   always_comb begin
      wr_word = rd_word;
      for (int i = 0; i < 4; i++) begin
         wr_word[8*i +: 8] = be_s[i] ? wrep_s[8*i +: 8] : rd_word[8*i +: 8];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Latency-modelled data memory slave for the core's load/store interface.
//   One transaction outstanding; valid/ready on request and response.
//   Parameters: DEPTH_WORDS (power of 2) words of storage, LATENCY (1..15)
//   cycles from the accept edge to rsp_valid.
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     req_valid / req_ready      request handshake (ready only in IDLE)
//     req_we, req_addr           store select, byte address
//     req_width, req_usignext    access width, load zero-extend select
//     req_wdata                  right-aligned store data
//     rsp_valid / rsp_ready      response handshake
//     rsp_rdata, rsp_err         load result (0 for stores/errors), error flag
// ---------------------------------------------------------------------------
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_width,
   input  logic        req_usignext,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int         IDX_W  = $clog2(DEPTH_WORDS);
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   logic [31:0]      mem_q [DEPTH_WORDS];
   logic [IDX_W-1:0] idx_s;
   logic [31:0]      rd_word_s;
   logic [31:0]      wr_word_s;
   logic [31:0]      ld_data_s;
   logic             err_s;
   logic             accept_s;
   logic             mem_we_s;
   logic             unused_addr_s;

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        req_ready_q, req_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;

   // Address bits above the storage index alias onto the same words
   assign idx_s         = req_addr[IDX_W+1:2];
   assign unused_addr_s = ^req_addr[31:IDX_W+2];
   assign rd_word_s     = mem_q[idx_s];

   // req_ready_q is only high in IDLE, so it doubles as the accept qualifier
   assign accept_s = req_valid & req_ready_q;
   assign mem_we_s = accept_s & req_we & ~err_s & ~reset;

   mem_responder_lane_align u_align (
      .addr_lo  (req_addr[1:0]),
      .width    (req_width),
      .usignext (req_usignext),
      .wdata    (req_wdata),
      .rd_word  (rd_word_s),
      .err      (err_s),
      .wr_word  (wr_word_s),
      .ld_data  (ld_data_s)
   );

   // Storage: store commits on the accept edge; contents survive reset
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[idx_s] <= wr_word_s;
      end
   end

   // Next-state, latency counter and response capture
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               // Load data is sampled now, so later stores cannot alter it
               rsp_err_d   = err_s;
               rsp_rdata_d = req_we ? 32'h0000_0000 : ld_data_s;
               if (LATENCY == 1) begin
                  state_d = ST_RESP;
                  cnt_d   = 4'd0;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = LAT_M1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            // Leaving on the cycle the count would reach zero gives
            // rsp_valid exactly LATENCY cycles after the accept cycle
            if (cnt_q <= 4'd1) begin
               state_d = ST_RESP;
               cnt_d   = 4'd0;
            end else begin
               cnt_d   = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
      req_ready_d = (state_d == ST_IDLE);
      rsp_valid_d = (state_d == ST_RESP);
   end

   // FSM and response registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0000_0000;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule
